press_pulse_gen: RTL and testbench

Input conditioner that drives the playfield light chain of the tug-of-war game. It converts the two raw, bouncing, asynchronous player KEY inputs into clean single-cycle L/R move pulses, exactly one pulse per physical press. The light cells consume these pulses.
- Sits between the board KEY pins and the light chain.
- Arbitrates simultaneous presses so the chain never sees L and R high in the same cycle.

---
 rtl/press_pulse_gen_pkg.sv | 27 ++
 rtl/press_pulse_gen_if.sv | 31 +++
 rtl/press_pulse_gen_key_channel.sv | 107 ++++++++++
 rtl/press_pulse_gen.sv | 88 ++++++++
 tb/tb_press_pulse_gen.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/press_pulse_gen_pkg.sv
// +----------------------------------------------------------------------+
// | Module  : press_pkg                                                  |
// | Brief   : Shared types and constants for the press pulse generator:  |
// |           key channel state encoding and CPU-opponent LFSR setup.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package press_pkg;

  // Debounce FSM states of one key channel
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } key_state_t;

  // CPU opponent LFSR: 9-bit Fibonacci, x^9 + x^5 + 1
  localparam int          LFSR_W     = 9;
  localparam int          LFSR_TAP_A = 8;
  localparam int          LFSR_TAP_B = 4;
  localparam logic [8:0]  LFSR_SEED  = 9'h001;

endpackage

`default_nettype wire

// File: rtl/press_pulse_gen_if.sv
// +----------------------------------------------------------------------+
// | Module  : press_pulse_gen_if                                         |
// | Brief   : Key inputs, difficulty setting and move/held outputs of    |
// |           the press pulse generator.                                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

interface press_pulse_gen_if;
  logic       KeyL;
  logic       KeyR;
  logic [8:0] Difficulty;
  logic       L;
  logic       R;
  logic       LHeld;
  logic       RHeld;

  // Board / stimulus side
  modport master (
    output KeyL, KeyR, Difficulty,
    input  L, R, LHeld, RHeld
  );

  // Conditioner side
  modport slave (
    input  KeyL, KeyR, Difficulty,
    output L, R, LHeld, RHeld
  );
endinterface

`default_nettype wire

// File: rtl/press_pulse_gen_key_channel.sv
// +----------------------------------------------------------------------+
// | Module  : key_channel                                                |
// | Brief   : One player key: inversion, 2-flop synchronizer, debounce   |
// |           FSM with stability counter; emits a one-cycle press pulse  |
// |           and the debounced held level.                              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module key_channel
  import press_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key_n,
  output logic p,
  output logic held
);

  localparam int             c_CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  localparam logic [1:0] c_IDLE         = IDLE;
  localparam logic [1:0] c_PRESS_PEND   = PRESS_PEND;
  localparam logic [1:0] c_HELD         = HELD;
  localparam logic [1:0] c_RELEASE_PEND = RELEASE_PEND;

  logic            r_sync1;
  logic            r_sync2;
  logic [1:0]      r_state;
  logic [c_CW-1:0] r_cnt;
  logic            r_p;

  // Bring the inverted (active-high) key into the clock domain
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ~key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive agreeing samples; the counter restarts on every state change
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_p     <= 1'b0;
    end else begin
      r_p <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (r_sync2) begin
            r_state <= c_PRESS_PEND;
            r_cnt   <= c_ONE;
          end
        end
        c_PRESS_PEND: begin
          if (!r_sync2) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_LAST) begin
            r_state <= c_HELD;
            r_cnt   <= '0;
            r_p     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
        c_HELD: begin
          if (!r_sync2) begin
            r_state <= c_RELEASE_PEND;
            r_cnt   <= c_ONE;
          end
        end
        c_RELEASE_PEND: begin
          // A bounce back to pressed returns to HELD without a new pulse
          if (r_sync2) begin
            r_state <= c_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == c_LAST) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign p    = r_p;
  assign held = (r_state == c_HELD) || (r_state == c_RELEASE_PEND);

endmodule

`default_nettype wire

// File: rtl/press_pulse_gen.sv
// +----------------------------------------------------------------------+
// | Module  : press_pulse_gen                                            |
// | Brief   : Converts two raw bouncing player keys into clean one-cycle |
// |           L/R move pulses for the light chain; simultaneous pulses   |
// |           cancel. Define CPU_OPPONENT_EN to replace the right player |
// |           with an LFSR-driven CPU opponent gated by Difficulty.      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module press_pulse_gen
  import press_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  press_pulse_gen_if.slave   bus
);

  logic w_pl;
  logic w_pr;
  logic w_lheld;
  logic w_rheld;

  key_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .Clock (Clock),
    .Reset (Reset),
    .key_n (bus.KeyL),
    .p     (w_pl),
    .held  (w_lheld)
  );

`ifdef CPU_OPPONENT_EN
  localparam int             c_CDW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CDW-1:0] c_COOL = c_CDW'(DEBOUNCE_CYCLES);

  logic [LFSR_W-1:0] r_lfsr;
  logic [c_CDW-1:0]  r_cool;
  logic              r_cpu_p;
  logic              w_cand;
  logic              w_unused_keyr;

  assign w_unused_keyr = bus.KeyR;
  assign w_cand = (r_lfsr < bus.Difficulty) && (r_cool == '0);

  // CPU opponent: free-running LFSR compared against Difficulty, with a
  // cooldown so consecutive CPU presses are at least DEBOUNCE_CYCLES+1 apart
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_lfsr  <= LFSR_SEED;
      r_cool  <= '0;
      r_cpu_p <= 1'b0;
    end else begin
      r_lfsr  <= {r_lfsr[LFSR_W-2:0], r_lfsr[LFSR_TAP_A] ^ r_lfsr[LFSR_TAP_B]};
      r_cpu_p <= w_cand;
      if (w_cand)
        r_cool <= c_COOL;
      else if (r_cool != '0)
        r_cool <= r_cool - c_CDW'(1);
    end
  end

  assign w_pr    = r_cpu_p;
  assign w_rheld = r_cpu_p;
`else
  logic w_unused_difficulty;

  assign w_unused_difficulty = ^bus.Difficulty;

  key_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .Clock (Clock),
    .Reset (Reset),
    .key_n (bus.KeyR),
    .p     (w_pr),
    .held  (w_rheld)
  );
`endif

  // Registered pulses only, so the arbitration is glitch-free; a tie moves nothing
  assign bus.L     = w_pl & ~w_pr;
  assign bus.R     = w_pr & ~w_pl;
  assign bus.LHeld = w_lheld;
  assign bus.RHeld = w_rheld;

endmodule

`default_nettype wire

// File: tb/tb_press_pulse_gen.sv
// +----------------------------------------------------------------------+
// | Module  : tb_press_pulse_gen                                         |
// | Brief   : Directed bench for press_pulse_gen with a run-length       |
// |           debounce model and hand-computed timing/pulse-count checks.|
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_press_pulse_gen;

  localparam int D = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  press_pulse_gen_if bus ();

  press_pulse_gen #(.DEBOUNCE_CYCLES(D)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int vectors     = 0;
  int miscompares = 0;
  int nL          = 0;
  int nR          = 0;
  bit started     = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge Clock);
  endtask

  // Model: each channel's synchronized level is the key sampled two edges
  // earlier; the debounced level flips once the synchronized level has
  // disagreed with it for D consecutive samples. A flip to 1 is a pulse.
  bit m_raw [2];
  bit m_s1  [2];
  bit m_s2  [2];
  bit m_lvl [2];
  bit m_p   [2];
  int m_run [2];

  always @(posedge Clock) begin
    m_raw[0] = ~bus.KeyL;
    m_raw[1] = ~bus.KeyR;
    for (int c = 0; c < 2; c++) begin
      if (Reset) begin
        m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_lvl[c] = 1'b0;
        m_p[c] = 1'b0;  m_run[c] = 0;
      end else begin
        m_p[c] = 1'b0;
        if (m_s2[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_lvl[c] = m_s2[c];
            m_p[c]   = m_s2[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = m_raw[c];
      end
    end
  end

  // Every-cycle comparison against the model, plus pulse counting
  always @(negedge Clock) begin
    if (started) begin
      check("model_L",     32'(bus.L),     32'(m_p[0] & ~m_p[1]));
      check("model_R",     32'(bus.R),     32'(m_p[1] & ~m_p[0]));
      check("model_LHeld", 32'(bus.LHeld), 32'(m_lvl[0]));
      check("model_RHeld", 32'(bus.RHeld), 32'(m_lvl[1]));
      check("L_R_exclusive", 32'(bus.L & bus.R), 0);
      if (bus.L === 1'b1) nL++;
      if (bus.R === 1'b1) nR++;
    end
  end

  // Key was just driven pressed at this negedge: L must appear exactly in
  // the cycle after the sixth rising edge (edge k+5) and only there
  task automatic expect_press_timing(input string nm);
    for (int i = 0; i < 5; i++) begin
      step();
      check({nm, "_early"}, 32'(bus.L), 0);
    end
    step();
    check({nm, "_pulse"}, 32'(bus.L), 1);
    check({nm, "_held"},  32'(bus.LHeld), 1);
    step();
    check({nm, "_single"}, 32'(bus.L), 0);
  endtask

  initial begin
    bus.KeyL       = 1'b1;
    bus.KeyR       = 1'b1;
    bus.Difficulty = 9'd0;
    Reset          = 1'b1;
    repeat (2) step();
    started = 1'b1;
    check("rst_L",     32'(bus.L),     0);
    check("rst_R",     32'(bus.R),     0);
    check("rst_LHeld", 32'(bus.LHeld), 0);
    check("rst_RHeld", 32'(bus.RHeld), 0);
    Reset = 1'b0;

    // Idle keys: nothing moves
    repeat (4) step();
    check("idle_L",     32'(bus.L),     0);
    check("idle_LHeld", 32'(bus.LHeld), 0);

    // Clean hold of 20 cycles: one pulse, held until 4 stable released samples
    bus.KeyL = 1'b0;
    expect_press_timing("hold");
    repeat (13) step();
    check("hold_count", 32'(nL), 1);
    check("hold_level", 32'(bus.LHeld), 1);
    bus.KeyL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("release_still_held", 32'(bus.LHeld), 1);
    end
    step();
    check("release_done", 32'(bus.LHeld), 0);
    repeat (4) step();

    // Press bounce then stable press; release bounce then stable release
    bus.KeyL = 1'b0; step();
    bus.KeyL = 1'b1; step();
    bus.KeyL = 1'b0; step();
    bus.KeyL = 1'b1; step();
    check("bounce_no_pulse", 32'(nL), 1);
    bus.KeyL = 1'b0;
    repeat (12) step();
    check("bounce_one_pulse", 32'(nL), 2);
    bus.KeyL = 1'b1; step();
    bus.KeyL = 1'b0; step();
    bus.KeyL = 1'b1; step();
    bus.KeyL = 1'b0; step();
    bus.KeyL = 1'b1;
    repeat (10) step();
    check("release_bounce_count", 32'(nL), 2);
    check("release_bounce_level", 32'(bus.LHeld), 0);

    // Simultaneous press: tie, no movement, both held
    bus.KeyL = 1'b0;
    bus.KeyR = 1'b0;
    repeat (20) step();
    check("tie_L_count", 32'(nL), 2);
    check("tie_R_count", 32'(nR), 0);
    check("tie_LHeld",   32'(bus.LHeld), 1);
    check("tie_RHeld",   32'(bus.RHeld), 1);
    bus.KeyL = 1'b1;
    bus.KeyR = 1'b1;
    repeat (10) step();
    check("tie_release_L", 32'(bus.LHeld), 0);
    check("tie_release_R", 32'(bus.RHeld), 0);

    // Short right press (3 cycles) is rejected
    bus.KeyR = 1'b0;
    repeat (3) step();
    bus.KeyR = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("short_RHeld", 32'(bus.RHeld), 0);
    end
    check("short_R_count", 32'(nR), 0);

    // Reset during PRESS_PEND with the key still held: new press after reset
    bus.KeyL = 1'b0;
    repeat (3) step();
    Reset = 1'b1;
    step();
    check("midrst_LHeld", 32'(bus.LHeld), 0);
    Reset = 1'b0;
    expect_press_timing("post_reset");
    repeat (6) step();
    check("post_reset_count", 32'(nL), 3);
    bus.KeyL = 1'b1;
    repeat (10) step();
    check("final_R_count", 32'(nR), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
